// File: rtl/uart_receiver.sv
// 8N1 UART receiver: two-flop rx synchroniser, mid-bit sampling, one-cycle valid or
// frame_err strobe per frame.
module uart_receiver #(
    parameter int unsigned CLOCKS_PER_BIT = 217,
    parameter int unsigned CNT_WIDTH      = 8
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       rx,
    output logic [7:0] data_out,
    output logic       valid,
    output logic       frame_err,
    output logic       busy
);

    localparam logic [CNT_WIDTH-1:0] HALF = CNT_WIDTH'((CLOCKS_PER_BIT - 1) / 2);
    localparam logic [CNT_WIDTH-1:0] LAST = CNT_WIDTH'(CLOCKS_PER_BIT - 1);

    typedef enum logic [1:0] {StIdle, StStart, StData, StStop} state_t;

    state_t               state_q, state_d;
    logic [1:0]           sync_q;
    logic [CNT_WIDTH-1:0] timer_q, timer_d;
    logic [2:0]           index_q, index_d;
    logic [7:0]           shift_q, shift_d;
    logic [7:0]           data_q, data_d;
    logic                 valid_q, valid_d;
    logic                 ferr_q, ferr_d;
    logic                 rx_s;

    assign rx_s = sync_q[1];

    always_comb begin
        state_d = state_q;
        timer_d = timer_q;
        index_d = index_q;
        shift_d = shift_q;
        data_d  = data_q;
        valid_d = 1'b0;
        ferr_d  = 1'b0;
        case (state_q)
            StIdle: begin
                if (!rx_s) begin
                    timer_d = '0;
                    state_d = StStart;
                end
            end
            StStart: begin
                if (timer_q == HALF) begin
                    timer_d = '0;
                    index_d = '0;
                    // Line back high at mid-start means a glitch, not a frame.
                    state_d = rx_s ? StIdle : StData;
                end else begin
                    timer_d = timer_q + 1'b1;
                end
            end
            StData: begin
                if (timer_q == LAST) begin
                    timer_d          = '0;
                    shift_d[index_q] = rx_s;
                    if (index_q == 3'd7) begin
                        state_d = StStop;
                    end else begin
                        index_d = index_q + 3'd1;
                    end
                end else begin
                    timer_d = timer_q + 1'b1;
                end
            end
            StStop: begin
                if (timer_q == LAST) begin
                    timer_d = '0;
                    state_d = StIdle;
                    if (rx_s) begin
                        data_d  = shift_q;
                        valid_d = 1'b1;
                    end else begin
                        ferr_d = 1'b1;
                    end
                end else begin
                    timer_d = timer_q + 1'b1;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= StIdle;
            sync_q  <= 2'b11;
            timer_q <= '0;
            index_q <= '0;
            shift_q <= '0;
            data_q  <= '0;
            valid_q <= 1'b0;
            ferr_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            sync_q  <= {sync_q[0], rx};
            timer_q <= timer_d;
            index_q <= index_d;
            shift_q <= shift_d;
            data_q  <= data_d;
            valid_q <= valid_d;
            ferr_q  <= ferr_d;
        end
    end

    assign data_out  = data_q;
    assign valid     = valid_q;
    assign frame_err = ferr_q;
    assign busy      = (state_q != StIdle);

endmodule

// File: tb/tb_uart_receiver.sv
// Scoreboard bench for uart_receiver: default instance plus a CLOCKS_PER_BIT=8 instance.
module tb_uart_receiver;

    typedef struct {
        bit         err;
        logic [7:0] data;
        int         cyc;
    } exp_t;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       rx0 = 1'b1;
    logic       rx1 = 1'b1;
    logic [7:0] dout0, dout1;
    logic       valid0, valid1, ferr0, ferr1, busy0, busy1;

    int   cyc = 0;
    int   checks = 0;
    int   errors = 0;
    exp_t q0[$];
    exp_t q1[$];
    logic [7:0] lg0 = 8'h00;
    logic [7:0] lg1 = 8'h00;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    uart_receiver #(.CLOCKS_PER_BIT(217), .CNT_WIDTH(8)) dut0 (
        .clk(clk), .rst(rst), .rx(rx0), .data_out(dout0),
        .valid(valid0), .frame_err(ferr0), .busy(busy0)
    );

    uart_receiver #(.CLOCKS_PER_BIT(8), .CNT_WIDTH(3)) dut1 (
        .clk(clk), .rst(rst), .rx(rx1), .data_out(dout1),
        .valid(valid1), .frame_err(ferr1), .busy(busy1)
    );

    task automatic check_out(input int inst, input logic v, input logic f, input logic [7:0] d);
        exp_t e;
        bit   have;
        checks++;
        if (v && f) begin
            errors++;
            $display("FAIL both_strobes inst=%0d valid=1 frame_err=1 required at most one", inst);
        end
        if (inst == 0) begin
            have = (q0.size() > 0);
            if (have) e = q0.pop_front();
        end else begin
            have = (q1.size() > 0);
            if (have) e = q1.pop_front();
        end
        checks++;
        if (!have) begin
            errors++;
            $display("FAIL unexpected_out inst=%0d valid=%0b frame_err=%0b cyc=%0d required none",
                     inst, v, f, cyc + 1);
        end else begin
            if (f != e.err) begin
                errors++;
                $display("FAIL kind inst=%0d frame_err=%0b required %0b", inst, f, e.err);
            end
            checks++;
            if (d !== e.data) begin
                errors++;
                $display("FAIL data inst=%0d data_out=%02h required %02h", inst, d, e.data);
            end
            checks++;
            if (cyc + 1 != e.cyc) begin
                errors++;
                $display("FAIL timing inst=%0d strobe cycle=%0d required %0d", inst, cyc + 1, e.cyc);
            end
        end
    endtask

    always @(negedge clk) begin
        if (!rst) begin
            if (valid0 || ferr0) check_out(0, valid0, ferr0, dout0);
            if (valid1 || ferr1) check_out(1, valid1, ferr1, dout1);
        end
    end

    task automatic probe(input string name, input logic [7:0] got, input logic [7:0] req);
        checks++;
        if (got !== req) begin
            errors++;
            $display("FAIL %s got=%02h required %02h", name, got, req);
        end
    endtask

    task automatic idle(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // Caller must be aligned #1 after a posedge; returns aligned the same way.
    task automatic drive_frame(input int inst, input logic [7:0] data, input logic stop,
                               input int nbits);
        logic [9:0] frame;
        int         cpb;
        frame = {stop, data, 1'b0};
        cpb   = (inst == 0) ? 217 : 8;
        for (int i = 0; i < nbits; i++) begin
            if (inst == 0) rx0 = frame[i];
            else           rx1 = frame[i];
            repeat (cpb) @(posedge clk);
            #1;
        end
    endtask

    // Strobe is sampled high at edge p + 5 + HALF + 9*CPB (T0 = p + 3 via the synchroniser).
    task automatic send(input int inst, input logic [7:0] data, input logic stop);
        exp_t e;
        e.err = !stop;
        if (inst == 0) begin
            e.cyc  = cyc + 5 + 108 + 9 * 217;
            if (stop) lg0 = data;
            e.data = lg0;
            q0.push_back(e);
        end else begin
            e.cyc  = cyc + 5 + 3 + 9 * 8;
            if (stop) lg1 = data;
            e.data = lg1;
            q1.push_back(e);
        end
        drive_frame(inst, data, stop, 10);
    endtask

    initial begin
        int p;
        int k;

        rst = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;
        probe("reset_data_out", dout0, 8'h00);
        probe("reset_valid", {7'd0, valid0}, 8'h00);
        probe("reset_frame_err", {7'd0, ferr0}, 8'h00);
        probe("reset_busy", {7'd0, busy0}, 8'h00);
        idle(5);

        send(0, 8'hA5, 1'b1);
        idle(300);

        send(0, 8'h00, 1'b1);
        send(0, 8'hFF, 1'b1);
        idle(300);

        // Short low pulse: START aborts at mid-bit, busy drops at T0+110.
        p   = cyc;
        rx0 = 1'b0;
        idle(50);
        rx0 = 1'b1;
        k   = -1;
        for (int i = 0; i < 400; i++) begin
            @(negedge clk);
            if (!busy0) begin
                k = cyc;
                break;
            end
        end
        checks++;
        if (k != p + 112) begin
            errors++;
            $display("FAIL glitch_busy busy low after edge=%0d required %0d", k, p + 112);
        end
        @(posedge clk);
        #1;
        idle(300);

        send(0, 8'h11, 1'b1);
        idle(300);
        send(0, 8'h3C, 1'b0);
        rx0 = 1'b1;
        idle(400);

        // Reset in the middle of data bit 4 of 0xC3.
        drive_frame(0, 8'hC3, 1'b1, 5);
        rx0 = 1'b0;
        idle(100);
        rx0 = 1'b1;
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        lg0 = 8'h00;
        probe("midreset_data_out", dout0, 8'h00);
        probe("midreset_valid", {7'd0, valid0}, 8'h00);
        probe("midreset_frame_err", {7'd0, ferr0}, 8'h00);
        probe("midreset_busy", {7'd0, busy0}, 8'h00);
        idle(10);
        send(0, 8'h5A, 1'b1);
        idle(300);

        send(1, 8'h81, 1'b1);
        idle(50);

        for (int i = 0; i < 1000 && (q0.size() > 0 || q1.size() > 0); i++) @(posedge clk);
        checks++;
        if (q0.size() != 0 || q1.size() != 0) begin
            errors++;
            $display("FAIL missing_out pending inst0=%0d inst1=%0d required 0", q0.size(),
                     q1.size());
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
